seq_alu_adder: RTL and testbench



---
 rtl/seq_alu_adder_pkg.sv | 34 +++
 rtl/seq_alu_adder_if.sv | 30 +++
 rtl/seq_alu_slice.sv | 21 ++
 rtl/seq_alu_adder.sv | 111 +++++++++++
 tb/tb_seq_alu_adder.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/seq_alu_adder_pkg.sv
// Shared definitions for the sequential flag-producing adder.
//   op_e     : operation encodings (ADD, SUB, ADC, SBB)
//   state_e  : FSM state encodings
//   flags_t  : registered flag bundle
//   calc_nslice : number of slices a WIDTH-bit operand splits into
package seq_alu_adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic sign;
    logic zero;
    logic carry;
    logic parity;
    logic overflow;
  } flags_t;

  // Divisibility is checked at elaboration in the top level.
  function automatic int calc_nslice(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/seq_alu_adder_if.sv
// Handshake bus of seq_alu_adder.
//   request  : in_valid/in_ready, op, cin, a, b
//   response : out_valid/out_ready, sum, sign, zero, carry, parity, overflow
//   master = operand source / result consumer, slave = the adder.
interface seq_alu_adder_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             sign;
  logic             zero;
  logic             carry;
  logic             parity;
  logic             overflow;

  modport master (
    output in_valid, op, cin, a, b, out_ready,
    input  in_ready, out_valid, sum, sign, zero, carry, parity, overflow
  );

  modport slave (
    input  in_valid, op, cin, a, b, out_ready,
    output in_ready, out_valid, sum, sign, zero, carry, parity, overflow
  );
endinterface

// File: rtl/seq_alu_slice.sv
// Combinational SLICE-bit adder slice.
//   a, b, cin -> s, cout
//   c_msb_in : carry into the top bit of the slice (overflow detection)
module seq_alu_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);
  logic [SLICE:0] full;

  assign full     = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  assign s        = full[SLICE-1:0];
  assign cout     = full[SLICE];
  // sum bit = a ^ b ^ carry_in, so the incoming carry falls out by xor.
  assign c_msb_in = a[SLICE-1] ^ b[SLICE-1] ^ full[SLICE-1];
endmodule

// File: rtl/seq_alu_adder.sv
// Multi-cycle add/subtract with flags, one SLICE-bit slice per clock,
// LSB slice first, carry rippled through carry_r.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of seq_alu_adder_if (operands in, result+flags out)
// Accept at edge k -> out_valid after edge k+NSLICE; result held until
// out_ready, then IDLE for one cycle before the next accept.
module seq_alu_adder
  import seq_alu_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic clk,
  input  logic rst_n,
  seq_alu_adder_if.slave bus
);
  localparam int NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0 || NSLICE < 1) begin : g_bad_param
    $error("seq_alu_adder: WIDTH must be a positive multiple of SLICE");
  end

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_nxt;
  logic             carry_r;
  logic [IW-1:0]    idx;
  flags_t           flg_r, flg_nxt;
  logic [SLICE-1:0] s_sl;
  logic             cout_sl, cmsb_sl;
  logic             accept, last;

  assign accept = bus.in_valid && (state == ST_IDLE);
  assign last   = (idx == LAST);

  seq_alu_slice #(.SLICE(SLICE)) u_slice (
    .a        (a_r[int'(idx)*SLICE +: SLICE]),
    .b        (b_r[int'(idx)*SLICE +: SLICE]),
    .cin      (carry_r),
    .s        (s_sl),
    .cout     (cout_sl),
    .c_msb_in (cmsb_sl)
  );

  // Final sum is only complete combinationally on the last slice edge, so
  // flags are taken from sum_nxt rather than sum_r.
  always_comb begin
    sum_nxt = sum_r;
    sum_nxt[int'(idx)*SLICE +: SLICE] = s_sl;
    flg_nxt.sign     = sum_nxt[WIDTH-1];
    flg_nxt.zero     = ~|sum_nxt;
    flg_nxt.carry    = cout_sl;
    flg_nxt.parity   = ~^sum_nxt;
    flg_nxt.overflow = cmsb_sl ^ cout_sl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) state_nxt = ST_CALC;
      end
      ST_CALC: if (last) state_nxt = ST_DONE;
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      flg_r   <= '0;
    end else begin
      if (accept) begin
        a_r     <= bus.a;
        // SUB/SBB add the one's complement; the +1 comes via carry-in.
        b_r     <= bus.op[0] ? ~bus.b : bus.b;
        carry_r <= bus.op[1] ? bus.cin : bus.op[0];
        idx     <= '0;
      end else if (state == ST_CALC) begin
        sum_r   <= sum_nxt;
        carry_r <= cout_sl;
        idx     <= idx + 1'b1;
        if (last) flg_r <= flg_nxt;
      end
    end
  end

  assign bus.sum      = sum_r;
  assign bus.sign     = flg_r.sign;
  assign bus.zero     = flg_r.zero;
  assign bus.carry    = flg_r.carry;
  assign bus.parity   = flg_r.parity;
  assign bus.overflow = flg_r.overflow;
endmodule

// File: tb/tb_seq_alu_adder.sv
// Directed bench for seq_alu_adder at 16/4, 32/8 and 8/8.
module tb_seq_alu_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  seq_alu_adder_if #(.WIDTH(16)) if16 ();
  seq_alu_adder_if #(.WIDTH(32)) if32 ();
  seq_alu_adder_if #(.WIDTH(8))  if8 ();

  seq_alu_adder #(.WIDTH(16), .SLICE(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  seq_alu_adder #(.WIDTH(32), .SLICE(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  seq_alu_adder #(.WIDTH(8),  .SLICE(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

  // flag vectors below are {sign, zero, carry, parity, overflow}

  task automatic test_reset();
    nvec++; if (if16.out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got=%b exp=0", if16.out_valid); end
    nvec++; if (if16.in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready got=%b exp=1", if16.in_ready); end
    nvec++; if (if16.sum !== 16'h0) begin nerr++; $display("FAIL rst_sum got=%h exp=0000", if16.sum); end
    nvec++; if ({if16.sign, if16.zero, if16.carry, if16.parity, if16.overflow} !== 5'b0) begin
      nerr++; $display("FAIL rst_flags got=%b exp=00000", {if16.sign, if16.zero, if16.carry, if16.parity, if16.overflow}); end
    nvec++; if ({if32.out_valid, if32.in_ready, if8.out_valid, if8.in_ready} !== 4'b0101) begin
      nerr++; $display("FAIL rst_other got=%b exp=0101", {if32.out_valid, if32.in_ready, if8.out_valid, if8.in_ready}); end
  endtask

  task automatic test_arith16();
    logic [1:0]  vop [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    logic        vcin[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] va  [6] = '{16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000, 16'h1234, 16'h0010};
    logic [15:0] vb  [6] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h4321, 16'h0001};
    logic [15:0] vs  [6] = '{16'h8000, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h5556, 16'h000E};
    logic [4:0]  vf  [6] = '{5'b10001, 5'b01110, 5'b10000, 5'b00101, 5'b00010, 5'b00100};
    for (int i = 0; i < 6; i++) begin
      nvec++; if (if16.in_ready !== 1'b1) begin nerr++; $display("FAIL a16_ready[%0d] got=%b exp=1", i, if16.in_ready); end
      if16.in_valid = 1'b1; if16.op = vop[i]; if16.cin = vcin[i]; if16.a = va[i]; if16.b = vb[i];
      @(posedge clk); #1;
      if16.in_valid = 1'b0; if16.a = 16'hDEAD; if16.b = 16'hBEEF;
      for (int c = 1; c < 4; c++) begin
        @(posedge clk); #1;
        nvec++; if (if16.out_valid !== 1'b0) begin nerr++; $display("FAIL a16_early[%0d] edge=%0d got=%b exp=0", i, c, if16.out_valid); end
      end
      @(posedge clk); #1;
      nvec++; if (if16.out_valid !== 1'b1) begin nerr++; $display("FAIL a16_latency[%0d] got=%b exp=1", i, if16.out_valid); end
      nvec++; if (if16.sum !== vs[i]) begin nerr++; $display("FAIL a16_sum[%0d] got=%h exp=%h", i, if16.sum, vs[i]); end
      nvec++; if ({if16.sign, if16.zero, if16.carry, if16.parity, if16.overflow} !== vf[i]) begin
        nerr++; $display("FAIL a16_flags[%0d] got=%b exp=%b", i, {if16.sign, if16.zero, if16.carry, if16.parity, if16.overflow}, vf[i]); end
      if16.out_ready = 1'b1;
      @(posedge clk); #1;
      if16.out_ready = 1'b0;
      nvec++; if ({if16.out_valid, if16.in_ready} !== 2'b01) begin
        nerr++; $display("FAIL a16_release[%0d] got=%b exp=01", i, {if16.out_valid, if16.in_ready}); end
    end
  endtask

  task automatic test_backpressure();
    if16.in_valid = 1'b1; if16.op = 2'b00; if16.cin = 1'b0; if16.a = 16'h0001; if16.b = 16'h0002;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // Offer a new operation while the result is stalled.
    if16.in_valid = 1'b1; if16.a = 16'hFFFF; if16.b = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      nvec++; if ({if16.out_valid, if16.in_ready} !== 2'b10) begin
        nerr++; $display("FAIL bp_hs[%0d] got=%b exp=10", c, {if16.out_valid, if16.in_ready}); end
      nvec++; if (if16.sum !== 16'h0003 || {if16.sign, if16.zero, if16.carry, if16.parity, if16.overflow} !== 5'b00010) begin
        nerr++; $display("FAIL bp_hold[%0d] got=%h/%b exp=0003/00010", c, if16.sum, {if16.sign, if16.zero, if16.carry, if16.parity, if16.overflow}); end
      @(posedge clk); #1;
    end
    if16.in_valid = 1'b0;
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
    nvec++; if ({if16.out_valid, if16.in_ready} !== 2'b01) begin
      nerr++; $display("FAIL bp_release got=%b exp=01", {if16.out_valid, if16.in_ready}); end
    nvec++; if (if16.sum !== 16'h0003) begin nerr++; $display("FAIL bp_idle_sum got=%h exp=0003", if16.sum); end
    @(posedge clk); #1;
    nvec++; if ({if16.out_valid, if16.in_ready} !== 2'b01) begin
      nerr++; $display("FAIL bp_idle got=%b exp=01", {if16.out_valid, if16.in_ready}); end
  endtask

  task automatic test_reset_mid();
    if16.in_valid = 1'b1; if16.op = 2'b00; if16.a = 16'h1111; if16.b = 16'h1111;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Slices 0 and 1 are written; slice 2 is in progress.
    rst_n = 1'b0;
    #1;
    nvec++; if ({if16.out_valid, if16.in_ready} !== 2'b01) begin
      nerr++; $display("FAIL rm_hs got=%b exp=01", {if16.out_valid, if16.in_ready}); end
    nvec++; if (if16.sum !== 16'h0000) begin nerr++; $display("FAIL rm_sum got=%h exp=0000", if16.sum); end
    @(negedge clk);
    rst_n = 1'b1;
    if16.in_valid = 1'b1; if16.a = 16'h0102; if16.b = 16'h0304;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (if16.out_valid !== 1'b1 || if16.sum !== 16'h0406) begin
      nerr++; $display("FAIL rm_next got=%b/%h exp=1/0406", if16.out_valid, if16.sum); end
    nvec++; if ({if16.sign, if16.zero, if16.carry, if16.parity, if16.overflow} !== 5'b00000) begin
      nerr++; $display("FAIL rm_flags got=%b exp=00000", {if16.sign, if16.zero, if16.carry, if16.parity, if16.overflow}); end
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
  endtask

  task automatic test_w32();
    logic [31:0] va[2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vs[2] = '{32'h8000_0000, 32'h0000_0000};
    logic [4:0]  vf[2] = '{5'b10001, 5'b01110};
    for (int i = 0; i < 2; i++) begin
      if32.in_valid = 1'b1; if32.op = 2'b00; if32.cin = 1'b0; if32.a = va[i]; if32.b = 32'h1;
      @(posedge clk); #1;
      if32.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nvec++; if (if32.out_valid !== 1'b0) begin nerr++; $display("FAIL w32_early[%0d] got=%b exp=0", i, if32.out_valid); end
      @(posedge clk); #1;
      nvec++; if (if32.out_valid !== 1'b1 || if32.sum !== vs[i]) begin
        nerr++; $display("FAIL w32_sum[%0d] got=%b/%h exp=1/%h", i, if32.out_valid, if32.sum, vs[i]); end
      nvec++; if ({if32.sign, if32.zero, if32.carry, if32.parity, if32.overflow} !== vf[i]) begin
        nerr++; $display("FAIL w32_flags[%0d] got=%b exp=%b", i, {if32.sign, if32.zero, if32.carry, if32.parity, if32.overflow}, vf[i]); end
      if32.out_ready = 1'b1;
      @(posedge clk); #1;
      if32.out_ready = 1'b0;
    end
  endtask

  task automatic test_w8();
    logic [7:0] va[2] = '{8'h7F, 8'hFF};
    logic [7:0] vs[2] = '{8'h80, 8'h00};
    logic [4:0] vf[2] = '{5'b10001, 5'b01110};
    for (int i = 0; i < 2; i++) begin
      if8.in_valid = 1'b1; if8.op = 2'b00; if8.cin = 1'b0; if8.a = va[i]; if8.b = 8'h01;
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
      nvec++; if ({if8.out_valid, if8.in_ready} !== 2'b00) begin
        nerr++; $display("FAIL w8_calc[%0d] got=%b exp=00", i, {if8.out_valid, if8.in_ready}); end
      @(posedge clk); #1;
      nvec++; if (if8.out_valid !== 1'b1 || if8.sum !== vs[i]) begin
        nerr++; $display("FAIL w8_sum[%0d] got=%b/%h exp=1/%h", i, if8.out_valid, if8.sum, vs[i]); end
      nvec++; if ({if8.sign, if8.zero, if8.carry, if8.parity, if8.overflow} !== vf[i]) begin
        nerr++; $display("FAIL w8_flags[%0d] got=%b exp=%b", i, {if8.sign, if8.zero, if8.carry, if8.parity, if8.overflow}, vf[i]); end
      if8.out_ready = 1'b1;
      @(posedge clk); #1;
      if8.out_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if16.in_valid = 1'b0; if16.op = 2'b00; if16.cin = 1'b0; if16.a = '0; if16.b = '0; if16.out_ready = 1'b0;
    if32.in_valid = 1'b0; if32.op = 2'b00; if32.cin = 1'b0; if32.a = '0; if32.b = '0; if32.out_ready = 1'b0;
    if8.in_valid  = 1'b0; if8.op  = 2'b00; if8.cin  = 1'b0; if8.a  = '0; if8.b  = '0; if8.out_ready  = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_arith16();
    test_backpressure();
    test_reset_mid();
    test_w32();
    test_w8();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
